adc_trigger_capture: RTL and testbench

Triggered capture buffer that consumes the 12-bit deserialized sample stream of one AD9228 channel, already in the `clk` domain, and records a fixed-length window around a threshold-crossing or forced trigger. It keeps a programmable number of pre-trigger samples in a circular buffer and fills the rest of the window after the trigger. It then streams the window out in time order over a valid/ready interface to the readout logic. One instance serves one ADC channel.

---
 rtl/adc_trigger_capture_if.sv | 17 +
 rtl/adc_trigger_capture.sv | 251 +++++++++++++++++++++++++
 tb/tb_adc_trigger_capture.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_trigger_capture_if.sv
// Readout stream between the capture buffer and the readout logic.
//   rd_data  - window sample, oldest first
//   rd_valid - rd_data is valid
//   rd_ready - consumer accepts rd_data on this edge
//   rd_last  - final sample of the window, qualified by rd_valid
// The capture buffer is the master; the consumer is the slave.
interface adc_trigger_capture_if #(
  parameter int DATA_WIDTH = 12
) ();
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  rd_last;

  modport master (output rd_data, output rd_valid, output rd_last, input rd_ready);
  modport slave  (input rd_data, input rd_valid, input rd_last, output rd_ready);
endinterface

// File: rtl/adc_trigger_capture.sv
// Triggered capture buffer for one ADC channel. Keeps pre_trig samples of
// history in a circular RAM, waits for a threshold crossing (or a forced
// trigger), fills the remainder of a DEPTH-sample window, then streams the
// window out oldest-first.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   sample_in/valid - sample stream
//   arm             - start a capture (IDLE only)
//   threshold       - trigger level, unsigned, live
//   trig_falling    - 0 rising / 1 falling crossing, latched at arm
//   force_trig      - make the next ARMED sample the trigger
//   pre_trig        - pre-trigger sample count, latched at arm
//   rd              - readout stream (master)
//   busy            - not IDLE
//   triggered       - trigger seen, until return to IDLE
//   done            - one-cycle pulse after the last sample is accepted
module adc_trigger_capture #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic                  arm,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic                  trig_falling,
  input  logic                  force_trig,
  input  logic [ADDR_W-1:0]     pre_trig,
  adc_trigger_capture_if.master rd,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done
);

  typedef enum logic [2:0] {ST_IDLE, ST_PRETRIG, ST_ARMED, ST_POST, ST_READOUT} state_t;

  localparam logic [ADDR_W-1:0] A_ZERO   = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] A_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] A_MAX    = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   RD_TOTAL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   RD_LAST  = {1'b0, {ADDR_W{1'b1}}};

  state_t                state_r, state_n;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_r, cnt_r, pre_trig_r, remain_r, rd_addr_r;
  logic [ADDR_W:0]       rd_cnt_r;
  logic                  falling_r, prev_valid_r, force_pend_r;
  logic [DATA_WIDTH-1:0] prev_r;
  logic                  triggered_r, done_r, busy_r;
  logic [DATA_WIDTH-1:0] ram_q_r, out_data_r, skid_data_r;
  logic                  ram_q_vld_r, ram_q_last_r;
  logic                  out_valid_r, out_last_r, skid_valid_r, skid_last_r;

  logic                  load_arm_s, wr_en_s, trig_s, issue_s, pop_s, cross_s;
  logic [2:0]            occ_s;

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_n    = state_r;
    load_arm_s = 1'b0;
    wr_en_s    = 1'b0;
    trig_s     = 1'b0;
    issue_s    = 1'b0;
    pop_s      = out_valid_r && rd.rd_ready;
    occ_s      = {2'b00, out_valid_r} + {2'b00, skid_valid_r} + {2'b00, ram_q_vld_r};
    if (falling_r) begin
      cross_s = prev_valid_r && (prev_r >= threshold) && (sample_in < threshold);
    end else begin
      cross_s = prev_valid_r && (prev_r < threshold) && (sample_in >= threshold);
    end
    case (state_r)
      ST_IDLE: begin
        if (arm) begin
          load_arm_s = 1'b1;
          state_n    = (pre_trig == A_ZERO) ? ST_ARMED : ST_PRETRIG;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_PRETRIG: begin
        if (sample_valid) begin
          wr_en_s = 1'b1;
          state_n = ((cnt_r + A_ONE) == pre_trig_r) ? ST_ARMED : ST_PRETRIG;
        end else begin
          state_n = ST_PRETRIG;
        end
      end
      ST_ARMED: begin
        if (sample_valid) begin
          wr_en_s = 1'b1;
          if (force_pend_r || cross_s) begin
            trig_s  = 1'b1;
            // With pre_trig = DEPTH-1 the trigger sample completes the window.
            state_n = (pre_trig_r == A_MAX) ? ST_READOUT : ST_POST;
          end else begin
            state_n = ST_ARMED;
          end
        end else begin
          state_n = ST_ARMED;
        end
      end
      ST_POST: begin
        if (sample_valid) begin
          wr_en_s = 1'b1;
          state_n = (remain_r == A_ONE) ? ST_READOUT : ST_POST;
        end else begin
          state_n = ST_POST;
        end
      end
      ST_READOUT: begin
        // Issue a RAM read only when its data is guaranteed a slot in the
        // two-entry output buffer one cycle later, assuming no further pop.
        if ((rd_cnt_r != RD_TOTAL) && (pop_s ? (occ_s <= 3'd2) : (occ_s <= 3'd1))) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
        if (pop_s && out_last_r) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_READOUT;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_n;
  end

  // Sample RAM: write port from the capture side, registered read port.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem[wr_ptr_r] <= sample_in;
    if (issue_s) ram_q_r <= mem[rd_addr_r];
  end

  // Capture pointers, trigger bookkeeping and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r     <= A_ZERO;
      cnt_r        <= A_ZERO;
      pre_trig_r   <= A_ZERO;
      falling_r    <= 1'b0;
      prev_r       <= {DATA_WIDTH{1'b0}};
      prev_valid_r <= 1'b0;
      force_pend_r <= 1'b0;
      remain_r     <= A_ZERO;
      rd_addr_r    <= A_ZERO;
      rd_cnt_r     <= {(ADDR_W+1){1'b0}};
      ram_q_vld_r  <= 1'b0;
      ram_q_last_r <= 1'b0;
      triggered_r  <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      if (load_arm_s) begin
        wr_ptr_r     <= A_ZERO;
        cnt_r        <= A_ZERO;
        prev_valid_r <= 1'b0;
        pre_trig_r   <= pre_trig;
        falling_r    <= trig_falling;
        rd_cnt_r     <= {(ADDR_W+1){1'b0}};
      end else begin
        if (wr_en_s) wr_ptr_r <= wr_ptr_r + A_ONE;
        if ((state_r == ST_PRETRIG) && sample_valid) cnt_r <= cnt_r + A_ONE;
        if (sample_valid && ((state_r == ST_PRETRIG) || (state_r == ST_ARMED))) begin
          prev_r       <= sample_in;
          prev_valid_r <= 1'b1;
        end
        if (issue_s) begin
          rd_addr_r <= rd_addr_r + A_ONE;
          rd_cnt_r  <= rd_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
        end
      end
      // Clearing wins over a force pulse that lands on the trigger edge.
      if (trig_s || (state_r == ST_IDLE)) begin
        force_pend_r <= 1'b0;
      end else if (force_trig && ((state_r == ST_PRETRIG) || (state_r == ST_ARMED))) begin
        force_pend_r <= 1'b1;
      end
      if (trig_s) begin
        // Readout starts pre_trig slots behind the trigger sample.
        rd_addr_r <= wr_ptr_r - pre_trig_r;
        remain_r  <= A_MAX - pre_trig_r;
      end else if ((state_r == ST_POST) && sample_valid) begin
        remain_r <= remain_r - A_ONE;
      end
      if (trig_s) triggered_r <= 1'b1;
      else if (state_n == ST_IDLE) triggered_r <= 1'b0;
      ram_q_vld_r  <= issue_s;
      if (issue_s) ram_q_last_r <= (rd_cnt_r == RD_LAST);
      done_r <= pop_s && out_last_r && (state_r == ST_READOUT);
      busy_r <= (state_n != ST_IDLE);
    end
  end

  // Two-entry output buffer: out_* drives the port, skid_* absorbs one
  // sample arriving from the RAM while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r   <= {DATA_WIDTH{1'b0}};
      out_last_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      skid_data_r  <= {DATA_WIDTH{1'b0}};
      skid_last_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (pop_s) begin
      if (skid_valid_r) begin
        out_data_r  <= skid_data_r;
        out_last_r  <= skid_last_r;
        out_valid_r <= 1'b1;
        if (ram_q_vld_r) begin
          skid_data_r  <= ram_q_r;
          skid_last_r  <= ram_q_last_r;
          skid_valid_r <= 1'b1;
        end else begin
          skid_valid_r <= 1'b0;
        end
      end else if (ram_q_vld_r) begin
        out_data_r  <= ram_q_r;
        out_last_r  <= ram_q_last_r;
        out_valid_r <= 1'b1;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else if (!out_valid_r) begin
      if (ram_q_vld_r) begin
        out_data_r  <= ram_q_r;
        out_last_r  <= ram_q_last_r;
        out_valid_r <= 1'b1;
      end
    end else if (ram_q_vld_r) begin
      skid_data_r  <= ram_q_r;
      skid_last_r  <= ram_q_last_r;
      skid_valid_r <= 1'b1;
    end
  end

  assign rd.rd_data  = out_data_r;
  assign rd.rd_valid = out_valid_r;
  assign rd.rd_last  = out_last_r;
  assign busy        = busy_r;
  assign triggered   = triggered_r;
  assign done        = done_r;

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Randomized bench for adc_trigger_capture (DEPTH=16). The reference model
// works on the list of accepted samples: it finds the trigger index from the
// crossing/force rules and slices the expected window out of that list.
module tb_adc_trigger_capture;
  localparam int DW    = 12;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] sample_in, threshold;
  logic          sample_valid, arm, trig_falling, force_trig;
  logic [AW-1:0] pre_trig;
  logic          busy, triggered, done;

  adc_trigger_capture_if #(.DATA_WIDTH(DW)) rd_if ();

  adc_trigger_capture #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .arm(arm), .threshold(threshold), .trig_falling(trig_falling),
    .force_trig(force_trig), .pre_trig(pre_trig), .rd(rd_if),
    .busy(busy), .triggered(triggered), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int stim[$];
  int win[$];
  int trig_k;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Index of the trigger sample in stim, or -1.
  function automatic int find_trigger(int pre, bit fall, int thr, int force_j);
    for (int i = pre; i < stim.size(); i++) begin
      bit crossing = 1'b0;
      if (i >= 1) begin
        if (fall) crossing = (stim[i-1] >= thr) && (stim[i] < thr);
        else      crossing = (stim[i-1] < thr) && (stim[i] >= thr);
      end
      if (crossing || (force_j >= 0 && i >= force_j)) return i;
    end
    return -1;
  endfunction

  task automatic do_arm(int pre, bit fall, int thr);
    @(negedge clk);
    check_val("idle_busy", busy, 0);
    arm = 1'b1; pre_trig = AW'(pre); trig_falling = fall; threshold = DW'(thr);
    sample_valid = 1'b0;
    @(negedge clk);
    arm = 1'b0;
    pre_trig = AW'($urandom);      // latched values must not follow the inputs
    trig_falling = ~fall;
    check_val("busy_rise", busy, 1);
  endtask

  task automatic feed(int n_feed, int force_j, bit gaps);
    for (int j = 0; j < n_feed; j++) begin
      if (j == force_j) begin
        force_trig = 1'b1; sample_valid = 1'b0; sample_in = DW'($urandom);
        @(negedge clk);
        force_trig = 1'b0;
      end
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          sample_valid = 1'b0; sample_in = DW'($urandom);
          arm = ($urandom_range(0, 3) == 0);
          force_trig = (j > trig_k) && ($urandom_range(0, 2) == 0);
          @(negedge clk);
          arm = 1'b0; force_trig = 1'b0;
        end
      end
      sample_valid = 1'b1; sample_in = DW'(stim[j]);
      @(negedge clk);
      sample_valid = 1'b0;
      check_val("triggered", triggered, (j >= trig_k));
    end
  endtask

  task automatic readout(bit bp);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [DW-1:0] held;
    logic held_last;
    while (got < DEPTH && cyc < 400) begin
      if (stalled) begin
        check_val("stall_valid", rd_if.rd_valid, 1);
        check_val("stall_data", rd_if.rd_data, held);
        check_val("stall_last", rd_if.rd_last, held_last);
      end
      check_val("done_early", done, 0);
      rd_if.rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      sample_valid = 1'($urandom_range(0, 1));
      sample_in = DW'($urandom);
      if (rd_if.rd_valid && rd_if.rd_ready) begin
        check_val("rd_data", rd_if.rd_data, win[got]);
        check_val("rd_last", rd_if.rd_last, (got == DEPTH - 1));
        got++;
        stalled = 1'b0;
      end else if (rd_if.rd_valid) begin
        stalled = 1'b1; held = rd_if.rd_data; held_last = rd_if.rd_last;
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check_val("rd_count", got, DEPTH);
    sample_valid = 1'b0; rd_if.rd_ready = 1'b0;
    check_val("done_pulse", done, 1);
    check_val("busy_fall", busy, 0);
    check_val("trig_clear", triggered, 0);
    @(negedge clk);
    check_val("done_once", done, 0);
  endtask

  task automatic run(int pre, bit fall, int thr, int force_j, bit gaps, bit bp);
    trig_k = find_trigger(pre, fall, thr, force_j);
    if (trig_k < 0) begin
      check_val("model_trig", 0, 1);
      return;
    end
    win.delete();
    for (int m = 0; m < DEPTH; m++) win.push_back(stim[trig_k - pre + m]);
    do_arm(pre, fall, thr);
    feed(trig_k - pre + DEPTH, force_j, gaps);
    readout(bp);
  endtask

  initial begin
    rst = 1'b1; sample_in = '0; sample_valid = 1'b0; arm = 1'b0;
    threshold = '0; trig_falling = 1'b0; force_trig = 1'b0; pre_trig = '0;
    rd_if.rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_rd_data", rd_if.rd_data, 0);
    check_val("rst_rd_valid", rd_if.rd_valid, 0);
    check_val("rst_rd_last", rd_if.rd_last, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_triggered", triggered, 0);
    check_val("rst_done", done, 0);
    rst = 1'b0;

    // Ramp, rising at 10, four samples of history: window 6..21.
    stim.delete(); for (int i = 0; i < 40; i++) stim.push_back(i);
    run(4, 1'b0, 10, -1, 1'b0, 1'b0);

    // Crossing during pre-trigger fill is ignored; the second 10 triggers.
    stim.delete();
    for (int i = 9; i <= 16; i++) stim.push_back(i);
    for (int i = 5; i <= 30; i++) stim.push_back(i);
    run(8, 1'b0, 10, -1, 1'b0, 1'b0);

    // Falling crossing at 50.
    stim.delete(); stim.push_back(200); stim.push_back(200); stim.push_back(50);
    for (int i = 0; i < 20; i++) stim.push_back($urandom_range(0, 4095));
    run(2, 1'b1, 100, -1, 1'b0, 1'b0);

    // Force while filling history: first armed sample triggers.
    stim.delete(); for (int i = 0; i < 30; i++) stim.push_back($urandom_range(0, 3999));
    run(3, 1'b0, 4000, 1, 1'b0, 1'b0);

    // Long armed wait wraps the buffer several times before the crossing.
    stim.delete();
    for (int i = 0; i < 44; i++) stim.push_back($urandom_range(0, 1999));
    stim.push_back(3000);
    for (int i = 0; i < 20; i++) stim.push_back($urandom_range(0, 4095));
    run(4, 1'b0, 2000, -1, 1'b0, 1'b0);

    // Backpressure with gapped input.
    stim.delete(); for (int i = 0; i < 40; i++) stim.push_back($urandom_range(0, 4095));
    run($urandom_range(0, 15), 1'b0, $urandom_range(1000, 3000), 20, 1'b1, 1'b1);

    // Reset in the post-trigger phase, then a clean capture.
    stim.delete(); for (int i = 0; i < 40; i++) stim.push_back(i);
    trig_k = find_trigger(4, 1'b0, 10, -1);
    do_arm(4, 1'b0, 10);
    feed(trig_k + 3, -1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_rd_data", rd_if.rd_data, 0);
    check_val("abort_rd_valid", rd_if.rd_valid, 0);
    check_val("abort_rd_last", rd_if.rd_last, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_triggered", triggered, 0);
    check_val("abort_done", done, 0);
    rst = 1'b0;
    run(4, 1'b0, 10, -1, 1'b0, 1'b0);

    // Random captures, including the 0 and DEPTH-1 history extremes.
    for (int r = 0; r < 6; r++) begin
      int pre;
      stim.delete();
      for (int i = 0; i < 50; i++) stim.push_back($urandom_range(0, 4095));
      pre = (r == 0) ? 0 : (r == 1) ? 15 : $urandom_range(0, 15);
      run(pre, 1'($urandom_range(0, 1)), $urandom_range(500, 3500),
          $urandom_range(0, 30), 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
